// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 command/response codes, sequencer states, fail codes and step indices
package ps2_pkg;
   localparam logic [7:0] CMD_RESET         = 8'hFF;
   localparam logic [7:0] CMD_SET_TYPEMATIC = 8'hF3;
   localparam logic [7:0] CMD_SET_LED       = 8'hED;
   localparam logic [7:0] CMD_ENABLE        = 8'hF4;
   localparam logic [7:0] RSP_ACK           = 8'hFA;
   localparam logic [7:0] RSP_RESEND        = 8'hFE;
   localparam logic [7:0] RSP_BAT_OK        = 8'hAA;
   localparam logic [7:0] RSP_BAT_FAIL      = 8'hFC;
   localparam logic [7:0] BREAK_PREFIX      = 8'hF0;
   localparam logic [7:0] KEY_SPACE         = 8'h29;
   typedef enum logic [2:0] {IDLE, SEND, WAIT_SENT, WAIT_ACK, WAIT_BAT, READY, FAIL} state_e;
   localparam logic [2:0] FC_NONE   = 3'd0;
   localparam logic [2:0] FC_TX_ERR = 3'd1;
   localparam logic [2:0] FC_ACK_TO = 3'd2;
   localparam logic [2:0] FC_RETRY  = 3'd3;
   localparam logic [2:0] FC_BAT    = 3'd4;
   localparam logic [2:0] STEP_RESET         = 3'd0;
   localparam logic [2:0] STEP_TYPEMATIC_CMD = 3'd1;
   localparam logic [2:0] STEP_TYPEMATIC_VAL = 3'd2;
   localparam logic [2:0] STEP_LED_CMD       = 3'd3;
   localparam logic [2:0] STEP_LED_VAL       = 3'd4;
   localparam logic [2:0] STEP_ENABLE        = 3'd5;
endpackage

// File: rtl/ps2_resp_timer.sv
// ps2_resp_timer: clearable saturating timeout counter with terminal-count flag
module ps2_resp_timer #(
   parameter int W = 8
) (
   input  logic         inclock,
   input  logic         resetn,
   input  logic         clr_i,
   input  logic         en_i,
   input  logic [W-1:0] limit_i,
   output logic         tc_o
);
   logic [W-1:0] cnt_q, cnt_d;
   assign tc_o = cnt_q == limit_i;
   // next count: clear wins, otherwise count up and hold at the terminal value
   always_comb cnt_d = clr_i ? '0 : (en_i && !tc_o) ? cnt_q + 1'b1 : cnt_q;
   // counter register
   always_ff @(posedge inclock) cnt_q <= !resetn ? '0 : cnt_d;
endmodule

// File: rtl/ps2_kbd_config_seq.sv
// ps2_kbd_config_seq: PS/2 keyboard reset/config sequencer with LED updates and byte forwarding; PS2_HOTPLUG_REINIT_EN re-inits on 0xAA in READY
module ps2_kbd_config_seq
   import ps2_pkg::*;
#(
   parameter bit          AUTO_INIT   = 1'b1,
   parameter logic [7:0]  TYPEMATIC   = 8'h20,
   parameter int          ACK_TIMEOUT = 1_000_000,
   parameter int          BAT_TIMEOUT = 50_000_000,
   parameter int          MAX_RETRIES = 3
) (
   input  logic       inclock,
   input  logic       resetn,
   input  logic       start,
   input  logic       led_req,
   input  logic [2:0] led_val,
   output logic [7:0] the_command,
   output logic       send_command,
   input  logic       command_was_sent,
   input  logic       error_communication_timed_out,
   input  logic [7:0] received_data,
   input  logic       received_data_en,
   output logic [7:0] pass_data,
   output logic       pass_data_en,
   output logic       busy,
   output logic       ready,
   output logic       fail,
   output logic [2:0] fail_code
);
   localparam int TW = $clog2(BAT_TIMEOUT + 1);
   localparam int RW = $clog2(MAX_RETRIES + 1);
   localparam logic [TW-1:0] ACK_LIM = TW'(ACK_TIMEOUT - 1);
   localparam logic [TW-1:0] BAT_LIM = TW'(BAT_TIMEOUT - 1);
   localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRIES);
   state_e        state_q, state_d;
   logic [2:0]    step_q, step_d, led_q, led_d, fail_code_q, fail_code_d;
   logic [RW-1:0] retry_q, retry_d;
   logic [7:0]    cmd_q, cmd_d, pass_q, pass_d, rom_byte;
   logic          led_mode_q, led_mode_d, send_q, send_d, pass_en_q, pass_en_d;
   logic          tc, last_step, hotplug, rx_ack, rx_resend;
   assign rom_byte = step_q == STEP_RESET ? CMD_RESET :
                     step_q == STEP_TYPEMATIC_CMD ? CMD_SET_TYPEMATIC :
                     step_q == STEP_TYPEMATIC_VAL ? TYPEMATIC :
                     step_q == STEP_LED_CMD ? CMD_SET_LED :
                     step_q == STEP_LED_VAL ? {5'b0, led_q} : CMD_ENABLE;
   // the LED-update list is the ED/LED tail of the init list, ending one step early
   assign last_step = step_q == (led_mode_q ? STEP_LED_VAL : STEP_ENABLE);
   assign rx_ack    = received_data_en && received_data == RSP_ACK;
   assign rx_resend = received_data_en && received_data == RSP_RESEND;
`ifdef PS2_HOTPLUG_REINIT_EN
   assign hotplug = received_data_en && received_data == RSP_BAT_OK;
`else
   assign hotplug = 1'b0;
`endif
   assign the_command  = cmd_q;
   assign send_command = send_q;
   assign pass_data    = pass_q;
   assign pass_data_en = pass_en_q;
   assign busy         = state_q inside {SEND, WAIT_SENT, WAIT_ACK, WAIT_BAT};
   assign ready        = state_q == READY;
   assign fail         = state_q == FAIL;
   assign fail_code    = fail_code_q;
   // timer restarts on every state change and runs only while awaiting a response
   ps2_resp_timer #(.W(TW)) u_timer (
      .inclock (inclock),
      .resetn  (resetn),
      .clr_i   (state_d != state_q),
      .en_i    (state_q == WAIT_ACK || state_q == WAIT_BAT),
      .limit_i (state_q == WAIT_BAT ? BAT_LIM : ACK_LIM),
      .tc_o    (tc)
   );
   // next-state and output decode
   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      retry_d     = retry_q;
      led_d       = led_q;
      led_mode_d  = led_mode_q;
      cmd_d       = cmd_q;
      send_d      = send_q;
      pass_d      = pass_q;
      pass_en_d   = 1'b0;
      fail_code_d = fail_code_q;
      case (state_q)
         IDLE: if (AUTO_INIT || start) begin
            state_d = SEND;
            step_d  = STEP_RESET;
         end
         SEND: begin
            cmd_d   = rom_byte;
            send_d  = 1'b1;
            state_d = WAIT_SENT;
         end
         WAIT_SENT: if (error_communication_timed_out) begin
            send_d      = 1'b0;
            state_d     = FAIL;
            fail_code_d = FC_TX_ERR;
         end else if (command_was_sent) begin
            send_d  = 1'b0;
            state_d = WAIT_ACK;
         end
         WAIT_ACK: if (rx_ack) begin
            retry_d = '0;
            if (step_q == STEP_RESET) state_d = WAIT_BAT;
            else if (last_step) state_d = READY;
            else begin
               state_d = SEND;
               step_d  = step_q + 3'd1;
            end
         end else if (rx_resend) begin
            if (retry_q < RETRY_LIM) begin
               retry_d = retry_q + 1'b1;
               state_d = SEND;
            end else begin
               state_d     = FAIL;
               fail_code_d = FC_RETRY;
            end
         end else if (tc) begin
            state_d     = FAIL;
            fail_code_d = FC_ACK_TO;
         end
         WAIT_BAT: if (received_data_en && received_data == RSP_BAT_OK) begin
            state_d = SEND;
            step_d  = step_q + 3'd1;
         end else if ((received_data_en && received_data == RSP_BAT_FAIL) || tc) begin
            state_d     = FAIL;
            fail_code_d = FC_BAT;
         end
         READY: begin
            pass_en_d = received_data_en && !hotplug;
            if (pass_en_d) pass_d = received_data;
            if (led_req) led_d = led_val;
            if (start || hotplug) begin
               state_d    = SEND;
               step_d     = start ? STEP_RESET : STEP_TYPEMATIC_CMD;
               led_mode_d = 1'b0;
            end else if (led_req) begin
               state_d    = SEND;
               step_d     = STEP_LED_CMD;
               led_mode_d = 1'b1;
            end
         end
         FAIL: begin
            retry_d = '0;
            if (start) begin
               state_d     = SEND;
               step_d      = STEP_RESET;
               led_mode_d  = 1'b0;
               fail_code_d = FC_NONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   // state and output registers
   always_ff @(posedge inclock) begin
      if (!resetn) begin
         state_q     <= IDLE;
         step_q      <= STEP_RESET;
         retry_q     <= '0;
         led_q       <= '0;
         led_mode_q  <= 1'b0;
         cmd_q       <= '0;
         send_q      <= 1'b0;
         pass_q      <= '0;
         pass_en_q   <= 1'b0;
         fail_code_q <= FC_NONE;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         retry_q     <= retry_d;
         led_q       <= led_d;
         led_mode_q  <= led_mode_d;
         cmd_q       <= cmd_d;
         send_q      <= send_d;
         pass_q      <= pass_d;
         pass_en_q   <= pass_en_d;
         fail_code_q <= fail_code_d;
      end
   end
endmodule

// File: tb/tb_ps2_kbd_config_seq.sv
// tb_ps2_kbd_config_seq: directed self-checking bench for the PS/2 keyboard config sequencer
module tb_ps2_kbd_config_seq;
   localparam int ACK_TO = 40;
   localparam int BAT_TO = 60;
   logic       inclock = 1'b0;
   logic       resetn, start, led_req, command_was_sent, error_communication_timed_out, received_data_en;
   logic [2:0] led_val;
   logic [7:0] received_data;
   logic [7:0] the_command, pass_data;
   logic       send_command, pass_data_en, busy, ready, fail;
   logic [2:0] fail_code;
   int         errors = 0;
   int         checks = 0;
   int         pass_cnt = 0;

   ps2_kbd_config_seq #(.ACK_TIMEOUT(ACK_TO), .BAT_TIMEOUT(BAT_TO)) dut (
      .inclock                       (inclock),
      .resetn                        (resetn),
      .start                         (start),
      .led_req                       (led_req),
      .led_val                       (led_val),
      .the_command                   (the_command),
      .send_command                  (send_command),
      .command_was_sent              (command_was_sent),
      .error_communication_timed_out (error_communication_timed_out),
      .received_data                 (received_data),
      .received_data_en              (received_data_en),
      .pass_data                     (pass_data),
      .pass_data_en                  (pass_data_en),
      .busy                          (busy),
      .ready                         (ready),
      .fail                          (fail),
      .fail_code                     (fail_code)
   );

   always #5 inclock = ~inclock;

   always @(posedge inclock) if (pass_data_en === 1'b1) pass_cnt <= pass_cnt + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // wait (bounded) for a transmit request, capture the byte, then answer sent or tx error
   task automatic get_cmd(input bit tx_err, output logic [7:0] b);
      int n;
      n = 0;
      b = 'x;
      while (send_command !== 1'b1 && n < 200) begin
         @(negedge inclock);
         n++;
      end
      if (send_command === 1'b1) begin
         b = the_command;
         if (tx_err) error_communication_timed_out = 1'b1;
         else command_was_sent = 1'b1;
         @(negedge inclock);
         error_communication_timed_out = 1'b0;
         command_was_sent = 1'b0;
      end
   endtask

   task automatic rx(input logic [7:0] d);
      received_data = d;
      received_data_en = 1'b1;
      @(negedge inclock);
      received_data_en = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge inclock);
      start = 1'b0;
   endtask

   // keyboard model: acknowledge the next n commands, passing BAT after a reset
   task automatic ack_steps(input int n);
      logic [7:0] b;
      for (int i = 0; i < n; i++) begin
         get_cmd(1'b0, b);
         rx(8'hFA);
         if (b === 8'hFF) rx(8'hAA);
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      start = 1'b0;
      led_req = 1'b0;
      led_val = 3'b0;
      command_was_sent = 1'b0;
      error_communication_timed_out = 1'b0;
      received_data = 8'h00;
      received_data_en = 1'b0;
      repeat (3) @(negedge inclock);
      checks++;
      if ({the_command, send_command, pass_data, pass_data_en, busy, ready, fail, fail_code} !== 25'd0)
         begin errors++; $display("FAIL reset_values: got %h required 0", {the_command, send_command, pass_data, pass_data_en, busy, ready, fail, fail_code}); end
      resetn = 1'b1;
      @(negedge inclock);
      checks++;
      if (busy !== 1'b1 || send_command !== 1'b0)
         begin errors++; $display("FAIL auto_start: busy=%b send=%b required busy=1 send=0", busy, send_command); end
   endtask

   task automatic test_init();
      logic [7:0] exp [6] = '{8'hFF, 8'hF3, 8'h20, 8'hED, 8'h00, 8'hF4};
      logic [7:0] b;
      int p0;
      p0 = pass_cnt;
      for (int i = 0; i < 6; i++) begin
         get_cmd(1'b0, b);
         checks++;
         if (b !== exp[i]) begin errors++; $display("FAIL init_byte%0d: got %h required %h", i, b, exp[i]); end
         rx(8'hFA);
         if (i == 0) rx(8'hAA);
      end
      checks++;
      if (ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL init_ready: ready=%b busy=%b required 1/0", ready, busy); end
      checks++;
      if (pass_cnt !== p0) begin errors++; $display("FAIL init_no_forward: got %0d pulses required 0", pass_cnt - p0); end
   endtask

   task automatic test_resend();
      logic [7:0] b;
      int n;
      pulse_start();
      ack_steps(1);
      n = 0;
      for (int k = 0; k < 3; k++) begin
         get_cmd(1'b0, b);
         if (b === 8'hF3) n++;
         rx(k < 2 ? 8'hFE : 8'hFA);
      end
      checks++;
      if (n !== 3) begin errors++; $display("FAIL resend_count: got %0d F3 sends required 3", n); end
      ack_steps(4);
      checks++;
      if (ready !== 1'b1) begin errors++; $display("FAIL resend_complete: ready=%b required 1", ready); end
      pulse_start();
      ack_steps(1);
      n = 0;
      for (int k = 0; k < 4; k++) begin
         get_cmd(1'b0, b);
         if (b === 8'hF3) n++;
         rx(8'hFE);
      end
      checks++;
      if (n !== 4) begin errors++; $display("FAIL retry_sends: got %0d F3 sends required 4", n); end
      checks++;
      if (fail !== 1'b1 || fail_code !== 3'd3) begin errors++; $display("FAIL retries_exhausted: fail=%b code=%0d required 1/3", fail, fail_code); end
   endtask

   task automatic test_timeouts();
      logic [7:0] b;
      pulse_start();
      ack_steps(3);
      get_cmd(1'b0, b);
      checks++;
      if (b !== 8'hED) begin errors++; $display("FAIL to_cmd: got %h required ed", b); end
      repeat (ACK_TO - 1) @(negedge inclock);
      checks++;
      if (fail !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ack_to_early: fail=%b busy=%b required 0/1", fail, busy); end
      @(negedge inclock);
      checks++;
      if (fail !== 1'b1 || fail_code !== 3'd2) begin errors++; $display("FAIL ack_timeout: fail=%b code=%0d required 1/2", fail, fail_code); end
      pulse_start();
      checks++;
      if (busy !== 1'b1 || fail !== 1'b0 || fail_code !== 3'd0) begin errors++; $display("FAIL restart_clear: busy=%b fail=%b code=%0d required 1/0/0", busy, fail, fail_code); end
      get_cmd(1'b1, b);
      checks++;
      if (fail !== 1'b1 || fail_code !== 3'd1) begin errors++; $display("FAIL tx_error: fail=%b code=%0d required 1/1", fail, fail_code); end
   endtask

   task automatic test_bat();
      logic [7:0] b;
      pulse_start();
      get_cmd(1'b0, b);
      rx(8'hFA);
      rx(8'hFC);
      checks++;
      if (fail !== 1'b1 || fail_code !== 3'd4) begin errors++; $display("FAIL bat_fc: fail=%b code=%0d required 1/4", fail, fail_code); end
      pulse_start();
      get_cmd(1'b0, b);
      rx(8'hFA);
      repeat (BAT_TO - 1) @(negedge inclock);
      checks++;
      if (fail !== 1'b0) begin errors++; $display("FAIL bat_to_early: fail=%b required 0", fail); end
      @(negedge inclock);
      checks++;
      if (fail !== 1'b1 || fail_code !== 3'd4) begin errors++; $display("FAIL bat_timeout: fail=%b code=%0d required 1/4", fail, fail_code); end
   endtask

   task automatic test_led();
      logic [7:0] b;
      int p0;
      pulse_start();
      ack_steps(6);
      p0 = pass_cnt;
      led_req = 1'b1;
      led_val = 3'b101;
      @(negedge inclock);
      led_req = 1'b0;
      get_cmd(1'b0, b);
      checks++;
      if (b !== 8'hED) begin errors++; $display("FAIL led_cmd: got %h required ed", b); end
      rx(8'h29);
      rx(8'hFA);
      get_cmd(1'b0, b);
      checks++;
      if (b !== 8'h05) begin errors++; $display("FAIL led_byte: got %h required 05", b); end
      rx(8'hFA);
      checks++;
      if (ready !== 1'b1 || pass_cnt !== p0) begin errors++; $display("FAIL led_done: ready=%b pulses=%0d required 1/0", ready, pass_cnt - p0); end
      rx(8'h29);
      checks++;
      if (pass_data !== 8'h29 || pass_data_en !== 1'b1) begin errors++; $display("FAIL forward: data=%h en=%b required 29/1", pass_data, pass_data_en); end
      @(negedge inclock);
      checks++;
      if (pass_data_en !== 1'b0) begin errors++; $display("FAIL forward_pulse: en=%b required 0", pass_data_en); end
   endtask

   task automatic test_back_to_back();
      received_data = 8'h11;
      received_data_en = 1'b1;
      @(negedge inclock);
      received_data = 8'h22;
      checks++;
      if (pass_data !== 8'h11 || pass_data_en !== 1'b1) begin errors++; $display("FAIL b2b_first: data=%h en=%b required 11/1", pass_data, pass_data_en); end
      @(negedge inclock);
      received_data_en = 1'b0;
      checks++;
      if (pass_data !== 8'h22 || pass_data_en !== 1'b1) begin errors++; $display("FAIL b2b_second: data=%h en=%b required 22/1", pass_data, pass_data_en); end
   endtask

   task automatic test_start_led();
      logic [7:0] b;
      start = 1'b1;
      led_req = 1'b1;
      led_val = 3'b011;
      @(negedge inclock);
      start = 1'b0;
      led_req = 1'b0;
      get_cmd(1'b0, b);
      checks++;
      if (b !== 8'hFF) begin errors++; $display("FAIL start_wins: got %h required ff", b); end
      rx(8'hFA);
      rx(8'hAA);
      ack_steps(3);
      get_cmd(1'b0, b);
      checks++;
      if (b !== 8'h03) begin errors++; $display("FAIL start_led_latched: got %h required 03", b); end
      rx(8'hFA);
      ack_steps(1);
      checks++;
      if (ready !== 1'b1) begin errors++; $display("FAIL start_led_ready: ready=%b required 1", ready); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] b;
      int n;
      pulse_start();
      ack_steps(1);
      n = 0;
      while (send_command !== 1'b1 && n < 50) begin
         @(negedge inclock);
         n++;
      end
      checks++;
      if (send_command !== 1'b1 || the_command !== 8'hF3) begin errors++; $display("FAIL mid_cmd: send=%b cmd=%h required 1/f3", send_command, the_command); end
      resetn = 1'b0;
      @(negedge inclock);
      checks++;
      if (send_command !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset: send=%b busy=%b required 0/0", send_command, busy); end
      resetn = 1'b1;
      get_cmd(1'b0, b);
      checks++;
      if (b !== 8'hFF) begin errors++; $display("FAIL mid_restart: got %h required ff", b); end
      rx(8'hFA);
      rx(8'hAA);
      ack_steps(5);
   endtask

   task automatic test_hotplug();
      logic [7:0] b;
      rx(8'hAA);
`ifdef PS2_HOTPLUG_REINIT_EN
      checks++;
      if (busy !== 1'b1 || pass_data_en !== 1'b0) begin errors++; $display("FAIL hotplug_busy: busy=%b en=%b required 1/0", busy, pass_data_en); end
      get_cmd(1'b0, b);
      checks++;
      if (b !== 8'hF3) begin errors++; $display("FAIL hotplug_cmd: got %h required f3", b); end
      rx(8'hFA);
      ack_steps(4);
      checks++;
      if (ready !== 1'b1) begin errors++; $display("FAIL hotplug_ready: ready=%b required 1", ready); end
`else
      b = pass_data;
      checks++;
      if (b !== 8'hAA || pass_data_en !== 1'b1) begin errors++; $display("FAIL aa_forward: data=%h en=%b required aa/1", b, pass_data_en); end
`endif
   endtask

   initial begin
      test_reset();
      test_init();
      test_resend();
      test_timeouts();
      test_bat();
      test_led();
      test_back_to_back();
      test_start_led();
      test_reset_mid();
      test_hotplug();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ps2_kbd_config_seq.md
Name: ps2_kbd_config_seq

Overview:
Host-side command sequencer for the PS/2 keyboard port. It drives the PS2 controller's transmit interface to reset and configure the keyboard: reset, typematic, LEDs and scan enable. It then stays resident to service LED updates. In the READY state it forwards unconsumed received bytes to the key-decode logic, such as the space-key tracker. It owns the controller's command port exclusively.

Parameters:
- AUTO_INIT, 1: run the init sequence automatically after reset release.
- TYPEMATIC, 8'h20: typematic byte sent after 0xF3.
- ACK_TIMEOUT, 1_000_000: cycles to wait for ACK/RESEND after a command byte is sent (20 ms at 50 MHz).
- BAT_TIMEOUT, 50_000_000: cycles to wait for the BAT result after the 0xFA to 0xFF (1 s).
- MAX_RETRIES, 3: RESEND (0xFE) retransmissions allowed per byte.

Ports:
- inclock, in, 1: system clock, 50 MHz.
- resetn, in, 1: synchronous, active-low reset.
- start, in, 1: one-cycle pulse; re-run full init from READY or FAIL.
- led_req, in, 1: one-cycle pulse; send LED update. Honoured in READY only.
- led_val, in, 3: {caps, num, scroll}, sampled on accepted led_req.
- the_command, out, 8: byte to transmit.
- send_command, out, 1: transmit request to the PS2 controller.
- command_was_sent, in, 1: controller finished transmitting.
- error_communication_timed_out, in, 1: controller transmit failure.
- received_data, in, 8: received byte.
- received_data_en, in, 1: received byte valid, one cycle.
- pass_data, out, 8: forwarded byte.
- pass_data_en, out, 1: forwarded byte valid, one cycle.
- busy, out, 1: sequence in progress.
- ready, out, 1: keyboard configured, idle.
- fail, out, 1: sequence aborted.
- fail_code, out, 3: 1 = tx error, 2 = ACK timeout, 3 = retries exhausted, 4 = BAT fail (0xFC) or BAT timeout.

Behaviour:
- Clock and reset: clock inclock; reset resetn, synchronous, active-low.
- Reset values: the_command = 0, send_command = 0, pass_data = 0, pass_data_en = 0, busy = 0, ready = 0, fail = 0, fail_code = 0. Retry and timeout counters = 0. State = IDLE.
- A reset mid-operation abandons the transfer. send_command drops in the same clock edge.
- Init step list, held in a step ROM:
  - FF, then ACK, then BAT
  - F3, then ACK
  - TYPEMATIC, then ACK
  - ED, then ACK
  - LED byte {5'b0, led_reg}, then ACK (led_reg resets to 0)
  - F4, then ACK
- LED-update list: ED, ACK, LED byte, ACK.
- State IDLE: go to SEND at step 0 one cycle after reset release if AUTO_INIT = 1. Otherwise go on start.
- State SEND: load the_command from the step ROM. Assert send_command and go to WAIT_SENT.
  - the_command stays stable until the next SEND.
- State WAIT_SENT: hold send_command high.
  - On command_was_sent: drop send_command next cycle, clear the timeout counter, go to WAIT_ACK.
  - On error_communication_timed_out: go to FAIL with code 1.
  - If both fire in the same cycle, the error wins.
- State WAIT_ACK: the timeout counter increments every cycle. On received_data_en:
  - 0xFA: clear the retry count. Go to WAIT_BAT if the step is FF. Otherwise advance the step, or go to READY if it was the last step.
  - 0xFE: if retries < MAX_RETRIES, increment retries and return to SEND with the same step. Otherwise go to FAIL with code 3.
  - Any other byte: dropped. The timeout keeps running.
  - Counter reaching ACK_TIMEOUT-1 with no response: go to FAIL with code 2.
- State WAIT_BAT:
  - 0xAA: advance to the next step.
  - 0xFC: FAIL with code 4.
  - Timeout at BAT_TIMEOUT-1: FAIL with code 4.
  - Other bytes: dropped.
- State READY: ready = 1, busy = 0.
  - Each received byte is copied to pass_data, and pass_data_en pulses one cycle later. This is fixed one-cycle latency with no gaps.
  - led_req: latch led_val, run the LED-update list, and return to READY.
  - start: run the full init.
  - If led_req and start arrive in the same cycle, start wins and the new led_val is latched.
- State FAIL: fail = 1, and fail_code holds until start or reset. Bytes are not forwarded.
- busy = 1 in SEND, WAIT_SENT, WAIT_ACK and WAIT_BAT. No byte is forwarded while busy.
- led_req and start are ignored while busy.
- Counter widths: $clog2(BAT_TIMEOUT+1) for the timeout counter; $clog2(MAX_RETRIES+1) for the retry counter. Neither counter wraps: each saturates at its terminal value.

Optional Feature:
Macro PS2_HOTPLUG_REINIT_EN.
- Defined: in READY, a received 0xAA (keyboard self-reset or hot-plug) is not forwarded. It triggers the full init sequence starting from step F3; the FF/BAT steps are skipped.
- Undefined: 0xAA is forwarded like any other byte.

Decomposition:
- Shared package ps2_pkg holds:
  - command constants: CMD_RESET 8'hFF, CMD_SET_TYPEMATIC 8'hF3, CMD_SET_LED 8'hED, CMD_ENABLE 8'hF4
  - response constants: RSP_ACK 8'hFA, RSP_RESEND 8'hFE, RSP_BAT_OK 8'hAA, RSP_BAT_FAIL 8'hFC
  - the break prefix 8'hF0 and the space-key scancode 8'h29
  - the state enum and fail_code constants
- One sub-module, ps2_resp_timer: a loadable timeout counter with a terminal-count flag, shared by the ACK and BAT waits.

Test Plan:
- Normal init: with AUTO_INIT, model acks each byte and sends AA after FF. The sequence FF, F3, 20, ED, 00, F4 is observed. ready = 1 one cycle after the final FA, and no pass_data_en pulses during the sequence.
- Resend: model replies FE twice to F3, then FA. F3 is transmitted 3 times and the sequence completes. With 4 FEs: fail = 1, fail_code = 3.
- Timeouts: no reply after ED: fail_code = 2 exactly ACK_TIMEOUT cycles after command_was_sent. Controller raises error_communication_timed_out: fail_code = 1.
- LED update: in READY, led_req with led_val = 3'b101 produces ED, then 05. A byte 0x29 received during the update is not forwarded. After return to READY, 0x29 yields pass_data = 0x29 with pass_data_en one cycle later.
- Reset mid-sequence: resetn low during WAIT_SENT: send_command = 0 and busy = 0 next edge. On release the sequence restarts with FF.
- With PS2_HOTPLUG_REINIT_EN: AA in READY leads to busy = 1 and the_command = F3, and no pass_data_en pulse. Without the macro: pass_data = 0xAA is forwarded.
